// File: rtl/bnn_cmd_loader.sv
// Byte-stream command sequencer between the SPI byte receiver and the BNN core.
// Opcodes select a payload target or launch a run; payload is committed atomically.
module bnn_cmd_loader #(
  parameter int IN_BYTES = 1,
  parameter int W_BYTES  = 2,
  parameter int B_BYTES  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [8*IN_BYTES-1:0] inputs_o,
  output logic [8*W_BYTES-1:0]  weights_o,
  output logic [8*B_BYTES-1:0]  bias_o,
  output logic                  start_o,
  input  logic                  busy_i,
  output logic                  load_done_o,
  output logic                  run_done_o,
  output logic                  cmd_err_o,
  output logic [1:0]            state_o
);

  localparam int MAX_WB    = (W_BYTES > B_BYTES) ? W_BYTES : B_BYTES;
  localparam int MAX_BYTES = (IN_BYTES > MAX_WB) ? IN_BYTES : MAX_WB;
  localparam int SHW       = 8 * MAX_BYTES;
  localparam int CNT_W     = $clog2(MAX_BYTES) + 1;

  localparam logic [CNT_W-1:0] N_IN = CNT_W'(IN_BYTES);
  localparam logic [CNT_W-1:0] N_W  = CNT_W'(W_BYTES);
  localparam logic [CNT_W-1:0] N_B  = CNT_W'(B_BYTES);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_LOAD     = 2'd1,
    S_RUN_WAIT = 2'd2,
    S_BAD      = 2'd3
  } state_t;

  typedef enum logic [1:0] {T_IN, T_W, T_B} tgt_t;

  state_t                r_state;
  tgt_t                  r_tgt;
  logic [SHW-1:0]        r_shadow;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_commit;
  logic                  r_seen_busy;
  logic [8*IN_BYTES-1:0] r_inputs;
  logic [8*W_BYTES-1:0]  r_weights;
  logic [8*B_BYTES-1:0]  r_bias;
  logic                  r_start;
  logic                  r_load_done;
  logic                  r_run_done;
  logic                  r_cmd_err;

  logic                  w_accept;
  logic [SHW-1:0]        w_shift;
  logic [CNT_W-1:0]      w_cnt_next;
  logic [CNT_W-1:0]      w_need;

  // Held low during reset so the receiver never sees a spurious accept.
  assign rx_ready   = rst_n && (r_state == S_IDLE || r_state == S_LOAD);
  assign w_accept   = rx_valid && rx_ready;
  assign w_shift    = (r_shadow << 8) | SHW'(rx_data);
  assign w_cnt_next = r_cnt + 1'b1;

  always_comb begin
    case (r_tgt)
      T_IN:    w_need = N_IN;
      T_W:     w_need = N_W;
      T_B:     w_need = N_B;
      default: w_need = N_IN;
    endcase
  end

  // NOTE: every register below uses <= so all branches see the pre-edge values,
  // which lets a commit and a new opcode share one edge without interfering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_tgt       <= T_IN;
      r_shadow    <= '0;
      r_cnt       <= '0;
      r_commit    <= 1'b0;
      r_seen_busy <= 1'b0;
      r_inputs    <= '0;
      r_weights   <= '0;
      r_bias      <= '0;
      r_start     <= 1'b0;
      r_load_done <= 1'b0;
      r_run_done  <= 1'b0;
      r_cmd_err   <= 1'b0;
    end else begin
      r_start     <= 1'b0;
      r_load_done <= 1'b0;
      r_run_done  <= 1'b0;
      r_commit    <= 1'b0;

      // Commit lands one edge after the last payload byte, from the full shadow.
      if (r_commit) begin
        case (r_tgt)
          T_IN:    r_inputs  <= r_shadow[8*IN_BYTES-1:0];
          T_W:     r_weights <= r_shadow[8*W_BYTES-1:0];
          T_B:     r_bias    <= r_shadow[8*B_BYTES-1:0];
          default: ;
        endcase
        r_load_done <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (rx_data)
              8'hB1, 8'hB2, 8'hB3: begin
                r_tgt    <= (rx_data == 8'hB1) ? T_IN : (rx_data == 8'hB2) ? T_W : T_B;
                r_cnt    <= '0;
                r_shadow <= '0;
                r_state  <= S_LOAD;
              end
              8'hAE: begin
                if (busy_i) begin
                  r_cmd_err <= 1'b1;
                end else begin
                  r_start     <= 1'b1;
                  r_seen_busy <= 1'b0;
                  r_state     <= S_RUN_WAIT;
                end
              end
              8'hA0:   r_cmd_err <= 1'b0;
              8'h00:   ;
              default: r_cmd_err <= 1'b1;
            endcase
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_shadow <= w_shift;
            r_cnt    <= w_cnt_next;
            if (w_cnt_next == w_need) begin
              r_commit <= 1'b1;
              r_state  <= S_IDLE;
            end
          end
        end
        S_RUN_WAIT: begin
          if (busy_i) begin
            r_seen_busy <= 1'b1;
          end else if (r_seen_busy) begin
            r_run_done <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_cmd_err <= 1'b1;
        end
      endcase
    end
  end

  assign inputs_o    = r_inputs;
  assign weights_o   = r_weights;
  assign bias_o      = r_bias;
  assign start_o     = r_start;
  assign load_done_o = r_load_done;
  assign run_done_o  = r_run_done;
  assign cmd_err_o   = r_cmd_err;
  assign state_o     = r_state;

endmodule
